// File: rtl/harness_seq_pkg.sv
// Shared opcodes and state encoding for the harness command sequencer.
`timescale 1ns/1ps
package harness_seq_pkg;

  localparam logic [7:0] OP_DUMP    = 8'd104;
  localparam logic [7:0] OP_HALT    = 8'd105;
  localparam logic [7:0] OP_RST_ON  = 8'd106;
  localparam logic [7:0] OP_RST_OFF = 8'd107;
  localparam logic [7:0] OP_STEP    = 8'd108;
  localparam logic [7:0] OP_LOAD    = 8'd109;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_BOOT  = 3'd0;
  localparam seq_state_t ST_IDLE  = 3'd1;
  localparam seq_state_t ST_LOAD  = 3'd2;
  localparam seq_state_t ST_STEP  = 3'd3;
  localparam seq_state_t ST_DUMP  = 3'd4;
  localparam seq_state_t ST_HALT  = 3'd5;
  localparam seq_state_t ST_ERROR = 3'd6;

endpackage

// File: rtl/harness_rsp_serializer.sv
// Turns the parallel DUT output vector into an LSB-first valid/ready byte stream.
// Optional HARNESS_SEQ_SNAPSHOT_EN freezes dut_out at start for a coherent dump.
`timescale 1ns/1ps
module harness_rsp_serializer
  import harness_seq_pkg::*;
#(
  parameter int OUTPUT_WORDS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [OUTPUT_WORDS*32-1:0] dut_out,
  input  logic                      rsp_ready,
  output logic [7:0]                rsp_data,
  output logic                      rsp_valid,
  output logic                      busy,
  output logic                      last_xfer
);

  localparam int NB = OUTPUT_WORDS * 4;
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic          active;
  logic [IW-1:0] idx;
  logic [NB*8-1:0] src;
  logic [NB*8-1:0] shifted;

`ifdef HARNESS_SEQ_SNAPSHOT_EN
  logic [NB*8-1:0] snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) snap <= '0;
    else if (start) snap <= dut_out;
  end

  assign src = snap;
`else
  // Live mux is safe: the DUT is never stepped while a dump is in flight.
  assign src = dut_out;
`endif

  assign last_xfer = active && rsp_ready && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      idx    <= '0;
    end else if (start) begin
      active <= 1'b1;
      idx    <= '0;
    end else if (last_xfer) begin
      active <= 1'b0;
      idx    <= '0;
    end else if (active && rsp_ready) begin
      idx <= idx + 1'b1;
    end
  end

  assign shifted   = src >> {idx, 3'b000};
  assign rsp_data  = active ? shifted[7:0] : 8'h00;
  assign rsp_valid = active;
  assign busy      = active;

endmodule

// File: rtl/harness_cmd_sequencer.sv
// Byte-command sequencer owning DUT reset, input vector and step enable.
// Config macro: HARNESS_SEQ_SNAPSHOT_EN (snapshot dut_out at dump start).
//
// state    | meaning
// BOOT     | one cycle after reset, no commands taken
// IDLE     | decode opcodes
// LOAD     | shift payload bytes into staging register
// STEP     | dut_step high, down-counter running
// DUMP     | serializer streaming dut_out bytes
// HALT     | 'i' received, terminal until rst
// ERROR    | unknown opcode, terminal until rst
`timescale 1ns/1ps
module harness_cmd_sequencer
  import harness_seq_pkg::*;
#(
  parameter int INPUT_BYTES  = 4,
  parameter int OUTPUT_WORDS = 1,
  parameter int STEP_CYCLES  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                cmd_data,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [7:0]                rsp_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [INPUT_BYTES*8-1:0]  dut_in,
  output logic                      dut_rst,
  output logic                      dut_step,
  input  logic [OUTPUT_WORDS*32-1:0] dut_out,
  output logic                      done,
  output logic                      err,
  output logic [7:0]                err_code
);

  localparam int IN_W = INPUT_BYTES * 8;
  localparam int SCW  = $clog2(STEP_CYCLES + 1);
  localparam int LCW  = $clog2(INPUT_BYTES + 1);

  seq_state_t      state;
  logic [SCW-1:0]  step_cnt;
  logic [LCW-1:0]  load_cnt;
  logic [IN_W-1:0] stage;
  logic            commit;
  logic            accept;
  logic            dump_start;
  logic            ser_busy;
  logic            ser_last;

  assign cmd_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign accept     = cmd_valid && cmd_ready;
  assign dump_start = accept && (state == ST_IDLE) && (cmd_data == OP_DUMP);
  assign dut_step   = (state == ST_STEP);
  assign done       = (state == ST_HALT);
  assign err        = (state == ST_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BOOT;
      step_cnt <= '0;
      load_cnt <= '0;
      stage    <= '0;
      commit   <= 1'b0;
      dut_in   <= '0;
      dut_rst  <= 1'b1;
      err_code <= 8'h00;
    end else begin
      commit <= 1'b0;
      // dut_in follows the staging register one cycle after the final byte
      if (commit) dut_in <= stage;
      case (state)
        ST_BOOT: state <= ST_IDLE;
        ST_IDLE: begin
          if (accept) begin
            case (cmd_data)
              OP_RST_ON:  dut_rst <= 1'b1;
              OP_RST_OFF: dut_rst <= 1'b0;
              OP_STEP: begin
                state    <= ST_STEP;
                step_cnt <= SCW'(STEP_CYCLES);
              end
              OP_LOAD: begin
                state    <= ST_LOAD;
                load_cnt <= LCW'(INPUT_BYTES);
              end
              OP_DUMP: state <= ST_DUMP;
              OP_HALT: state <= ST_HALT;
              default: begin
                state    <= ST_ERROR;
                err_code <= cmd_data;
              end
            endcase
          end
        end
        ST_LOAD: begin
          if (accept) begin
            stage    <= (stage >> 8) | (IN_W'(cmd_data) << (IN_W - 8));
            load_cnt <= load_cnt - 1'b1;
            if (load_cnt == LCW'(1)) begin
              state  <= ST_IDLE;
              commit <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          if (step_cnt == SCW'(1)) state <= ST_IDLE;
          else step_cnt <= step_cnt - 1'b1;
        end
        ST_DUMP: if (ser_last) state <= ST_IDLE;
        default: state <= state;
      endcase
    end
  end

  harness_rsp_serializer #(
    .OUTPUT_WORDS(OUTPUT_WORDS)
  ) u_rsp_serializer (
    .clk       (clk),
    .rst       (rst),
    .start     (dump_start),
    .dut_out   (dut_out),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .busy      (ser_busy),
    .last_xfer (ser_last)
  );

endmodule

// File: tb/tb_harness_cmd_sequencer.sv
// Randomized self-checking bench for harness_cmd_sequencer against a behavioural model.
`timescale 1ns/1ps
module tb_harness_cmd_sequencer;

  localparam int IB = 4;
  localparam int OW = 1;
  localparam int SC = 3;
  localparam int NB = OW * 4;

  localparam logic [7:0] C_DUMP = 8'd104;
  localparam logic [7:0] C_HALT = 8'd105;
  localparam logic [7:0] C_RON  = 8'd106;
  localparam logic [7:0] C_ROFF = 8'd107;
  localparam logic [7:0] C_STEP = 8'd108;
  localparam logic [7:0] C_LOAD = 8'd109;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] cmd_data;
  logic cmd_valid;
  logic cmd_ready;
  logic [7:0] rsp_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [IB*8-1:0] dut_in;
  logic dut_rst;
  logic dut_step;
  logic [OW*32-1:0] dut_out;
  logic done;
  logic err;
  logic [7:0] err_code;

  int tests = 0;
  int fails = 0;

  logic mdl_rst;
  logic [IB*8-1:0] mdl_in;

  always #5 clk = ~clk;

  harness_cmd_sequencer #(
    .INPUT_BYTES(IB), .OUTPUT_WORDS(OW), .STEP_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .dut_in(dut_in), .dut_rst(dut_rst),
    .dut_step(dut_step), .dut_out(dut_out), .done(done), .err(err),
    .err_code(err_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mdl_rst = 1'b1;
    mdl_in = '0;
  endtask

  // Returns one ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout byte=%02h cmd_ready=%b expected 1", b, cmd_ready);
    end else begin
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; dut_out = $urandom;
    tick(); tick();
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    tests++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin fails++; $display("FAIL rst_rsp got v=%b d=%02h exp v=0 d=00", rsp_valid, rsp_data); end
    tests++; if (dut_in !== '0) begin fails++; $display("FAIL rst_dut_in got=%h exp=0", dut_in); end
    tests++; if (dut_rst !== 1'b1 || dut_step !== 1'b0) begin fails++; $display("FAIL rst_dut_ctl got rst=%b step=%b exp 1/0", dut_rst, dut_step); end
    tests++; if (done !== 1'b0 || err !== 1'b0 || err_code !== 8'h00) begin fails++; $display("FAIL rst_status got done=%b err=%b code=%02h exp 0/0/00", done, err, err_code); end
    rst = 1'b0;
    #1;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL boot_cmd_ready got=%b exp=0", cmd_ready); end
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
    mdl_rst = 1'b1; mdl_in = '0;
  endtask

  task automatic test_rst_cmds();
    realtime t0;
    logic [7:0] b;
    do_reset();
    send_byte(C_ROFF);
    tests++; if (dut_rst !== 1'b0) begin fails++; $display("FAIL rst_off got=%b exp=0", dut_rst); end
    send_byte(C_RON);
    tests++; if (dut_rst !== 1'b1) begin fails++; $display("FAIL rst_on got=%b exp=1", dut_rst); end
    for (int i = 0; i < 10; i++) begin
      b = ($urandom_range(0, 1) != 0) ? C_RON : C_ROFF;
      mdl_rst = (b == C_RON);
      t0 = $realtime;
      send_byte(b);
      tests++;
      if (dut_rst !== mdl_rst || ($realtime - t0) != 10.0) begin
        fails++;
        $display("FAIL rst_seq[%0d] got rst=%b dt=%0t exp rst=%b dt=10", i, dut_rst, $realtime - t0, mdl_rst);
      end
    end
  endtask

  task automatic test_load(input logic [7:0] b[IB], input bit gaps);
    logic [IB*8-1:0] expv = '0;
    for (int i = 0; i < IB; i++) expv = expv | ((IB*8)'(b[i]) << (8 * i));
    send_byte(C_LOAD);
    for (int i = 0; i < IB; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          tests++;
          if (dut_step !== 1'b0 || dut_in !== mdl_in) begin
            fails++;
            $display("FAIL load_gap got step=%b in=%h exp step=0 in=%h", dut_step, dut_in, mdl_in);
          end
        end
      end
      send_byte(b[i]);
      tests++;
      if (dut_in !== mdl_in) begin fails++; $display("FAIL load_early[%0d] got=%h exp=%h", i, dut_in, mdl_in); end
    end
    tick();
    mdl_in = expv;
    tests++; if (dut_in !== mdl_in) begin fails++; $display("FAIL load_commit got=%h exp=%h", dut_in, mdl_in); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL load_idle got cmd_ready=%b exp=1", cmd_ready); end
  endtask

  task automatic test_step(input int n_cmds);
    int step_n = 0, acc = 0, first = -1, last = -1, busy_ready = 0;
    bit will_acc;
    cmd_data = C_STEP; cmd_valid = 1'b1;
    for (int c = 0; c < 8 * n_cmds + 4; c++) begin
      will_acc = cmd_valid && cmd_ready;
      tick();
      if (will_acc) begin acc++; if (acc == n_cmds) cmd_valid = 1'b0; end
      if (dut_step) begin
        step_n++;
        if (first < 0) first = c;
        last = c;
        if (cmd_ready) busy_ready++;
      end
    end
    cmd_valid = 1'b0;
    tests++; if (step_n != n_cmds * SC) begin fails++; $display("FAIL step_count n=%0d got=%0d exp=%0d", n_cmds, step_n, n_cmds * SC); end
    tests++; if (first != 0) begin fails++; $display("FAIL step_start got=%0d exp=0", first); end
    tests++; if (last - first + 1 - step_n != n_cmds - 1) begin fails++; $display("FAIL step_gaps got=%0d exp=%0d", last - first + 1 - step_n, n_cmds - 1); end
    tests++; if (busy_ready != 0) begin fails++; $display("FAIL step_ready got=%0d ready cycles exp=0", busy_ready); end
  endtask

  task automatic test_dump(input logic [OW*32-1:0] val, input bit rnd);
    int k = 0, cyc = 0;
    bit hs;
    logic [7:0] e;
    dut_out = val; rsp_ready = 1'b0;
    send_byte(C_DUMP);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL dump_first_valid got=%b exp=1", rsp_valid); end
    while (k < NB && cyc < 100) begin
      e = 8'(val >> (8 * k));
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== e || dut_step !== 1'b0 || cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL dump_byte[%0d] got v=%b d=%02h step=%b rdy=%b exp v=1 d=%02h step=0 rdy=0", k, rsp_valid, rsp_data, dut_step, cmd_ready, e);
      end
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
      hs = rsp_valid && rsp_ready;
      tick();
      cyc++;
      if (hs) k++;
    end
    rsp_ready = 1'b0;
    tests++; if (k != NB) begin fails++; $display("FAIL dump_timeout got=%0d bytes exp=%0d", k, NB); end
    tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL dump_end got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_error(input logic [7:0] b);
    do_reset();
    send_byte(b);
    tests++;
    if (err !== 1'b1 || err_code !== b || cmd_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL error_%02h got err=%b code=%02h rdy=%b done=%b exp 1/%02h/0/0", b, err, err_code, cmd_ready, done, b);
    end
    cmd_data = C_ROFF; cmd_valid = 1'b1;
    repeat (3) tick();
    cmd_valid = 1'b0;
    tests++;
    if (err !== 1'b1 || dut_rst !== mdl_rst || cmd_ready !== 1'b0 || err_code !== b) begin
      fails++;
      $display("FAIL error_sticky got err=%b rst=%b rdy=%b code=%02h exp 1/%b/0/%02h", err, dut_rst, cmd_ready, err_code, mdl_rst, b);
    end
  endtask

  task automatic test_halt();
    do_reset();
    send_byte(C_HALT);
    tests++;
    if (done !== 1'b1 || cmd_ready !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL halt got done=%b rdy=%b err=%b exp 1/0/0", done, cmd_ready, err);
    end
    cmd_data = C_STEP; cmd_valid = 1'b1;
    repeat (3) tick();
    cmd_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || dut_step !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL halt_sticky got done=%b step=%b rdy=%b exp 1/0/0", done, dut_step, cmd_ready);
    end
  endtask

  task automatic test_abort();
    logic [7:0] b[IB];
    do_reset();
    for (int i = 0; i < IB; i++) b[i] = 8'($urandom_range(1, 255));
    test_load(b, 1'b0);
    send_byte(C_LOAD);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    rst = 1'b1;
    #1;
    tests++; if (dut_in !== '0 || dut_step !== 1'b0) begin fails++; $display("FAIL abort_load got in=%h step=%b exp 0/0", dut_in, dut_step); end
    tick();
    rst = 1'b0; mdl_in = '0; mdl_rst = 1'b1;
    for (int i = 0; i < IB; i++) b[i] = 8'($urandom);
    test_load(b, 1'b1);
    dut_out = $urandom;
    send_byte(C_DUMP);
    tick();
    rst = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin fails++; $display("FAIL abort_dump got v=%b d=%02h exp 0/00", rsp_valid, rsp_data); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] fb[IB];
    logic [7:0] rb;
    cmd_data = 8'h00; cmd_valid = 1'b0; rsp_ready = 1'b0; dut_out = '0; rst = 1'b1;
    mdl_rst = 1'b1; mdl_in = '0;
    test_reset();
    test_rst_cmds();
    fb = '{8'h11, 8'h22, 8'h33, 8'h44};
    test_load(fb, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < IB; i++) fb[i] = 8'($urandom);
      test_load(fb, 1'b1);
    end
    test_step(1);
    test_step(2);
    test_dump(32'hDEADBEEF, 1'b0);
    for (int r = 0; r < 3; r++) test_dump($urandom, 1'b1);
    test_error(8'h41);
    rb = 8'($urandom);
    while (rb >= C_DUMP && rb <= C_LOAD) rb = 8'($urandom);
    test_error(rb);
    test_halt();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/harness_cmd_sequencer.md
# harness_cmd_sequencer

Synthesizable command sequencer that drives a clock-enabled DUT from an 8-bit command byte stream, using the same opcodes as the simulation harness protocol ('h' dump, 'i' halt, 'j'/'k' reset assert/deassert, 'l' step, 'm' load). It sits between a host byte channel (UART, or the co-simulation pipe) and the DUT.
- Owns the DUT's reset, input vector and step enable.
- Serializes the DUT's output vector back to the host.

## Interface
- INPUT_BYTES, 4, width of DUT input vector in bytes (≥1)
- OUTPUT_WORDS, 1, width of DUT output vector in 32-bit words (≥1)
- STEP_CYCLES, 1, clk cycles of dut_step per 'l' command (≥1)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_data  in  8  command/payload byte
- cmd_valid  in  1  byte present
- cmd_ready  out  1  byte accepted when cmd_valid && cmd_ready
- rsp_data  out  8  dump byte
- rsp_valid  out  1  dump byte present
- rsp_ready  in  1  host accepts dump byte
- dut_in  out  INPUT_BYTES*8  DUT input vector
- dut_rst  out  1  DUT reset
- dut_step  out  1  DUT clock enable
- dut_out  in  OUTPUT_WORDS*32  DUT output vector
- done  out  1  'i' received
- err  out  1  unexpected opcode received
- err_code  out  8  offending opcode byte

## Operation
- States: BOOT, IDLE, LOAD, STEP, DUMP, HALT, ERROR. Reset → BOOT; BOOT → IDLE unconditionally after one cycle.
- cmd_ready is 1 only in IDLE and LOAD.
- Opcodes accepted in IDLE:
  - 'j' (106): dut_rst←1, stay IDLE.
  - 'k' (107): dut_rst←0, stay IDLE.
  - 'l' (108): → STEP; down-counter loaded with STEP_CYCLES; dut_step=1 each STEP cycle; → IDLE when the counter expires.
  - 'm' (109): → LOAD; the next INPUT_BYTES accepted bytes shift into a staging register as {byte, stage[top:8]}, so the first byte lands in bits [7:0]. dut_in is updated atomically from the staging register on the cycle after the final byte; → IDLE.
  - 'h' (104): → DUMP; emits OUTPUT_WORDS*4 bytes, least-significant byte first (byte k = dut_out[8k+7:8k]); → IDLE after the last handshake.
  - 'i' (105): → HALT; done=1; terminal until rst.
  - Any other byte: → ERROR; err=1, err_code=byte; terminal until rst.
- Bytes in LOAD are payload only and are never decoded as opcodes.
- rsp_valid is 1 only in DUMP. rsp_data/rsp_valid hold stable while rsp_ready=0.

## Timing
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, dut_in=0, dut_rst=1, dut_step=0, done=0, err=0, err_code=0.
- 'j'/'k': dut_rst changes on the edge that accepts the byte. One command per cycle is sustainable.
- 'l': dut_step is high for exactly STEP_CYCLES consecutive cycles, starting the cycle after acceptance. cmd_ready is 0 throughout; next acceptance is possible in the cycle after the last step cycle.
- 'm': dut_in changes exactly one cycle after the last payload handshake. cmd_valid gaps mid-payload are legal; state is held.
- 'h': first rsp_valid is in the cycle after acceptance. Throughput is one byte per cycle when rsp_ready=1.
- dut_step is never asserted in DUMP or LOAD.
- rst asserted mid-operation: aborts immediately. The partial payload is discarded, dut_in→0, dut_step→0, and the dump is truncated with no further bytes.

## Configuration
- HARNESS_SEQ_SNAPSHOT_EN defined:
  - dut_out is captured into a snapshot register on the 'h' acceptance edge.
  - All dump bytes come from the snapshot, so the dump is coherent even if the DUT free-runs.
- Undefined:
  - No snapshot register; each byte is muxed live from dut_out when presented.
  - Correct only because dut_step=0 during DUMP.

## Structure
- Package harness_seq_pkg holds:
  - opcode localparams OP_DUMP=104, OP_HALT=105, OP_RST_ON=106, OP_RST_OFF=107, OP_STEP=108, OP_LOAD=109;
  - the state enum.
- One sub-module, harness_rsp_serializer:
  - parallel OUTPUT_WORDS*32 vector → valid/ready byte stream, with byte counter;
  - contains the optional snapshot register;
  - start/busy handshake with the FSM.

## Test plan
- Post-reset: dut_rst=1, cmd_ready=0 in BOOT, then 1. Send 'k' → dut_rst=0 the next cycle. Send 'j' → dut_rst=1.
- INPUT_BYTES=4, send 'm',0x11,0x22,0x33,0x44 → dut_in=0x44332211 one cycle after the last byte, unchanged before it.
- STEP_CYCLES=3, send 'l' → dut_step high exactly 3 cycles and cmd_ready=0 during them. A back-to-back 'l' gives 6 step cycles total with 1 idle gap.
- dut_out=0xDEADBEEF, send 'h' with rsp_ready toggling every cycle → bytes EF,BE,AD,DE, each held while rsp_ready=0, then IDLE.
- Send 0x41 → err=1, err_code=0x41, cmd_ready stays 0. Send 'i' after a fresh reset → done=1, cmd_ready=0.
- Assert rst after 2 of 4 'm' payload bytes → dut_in=0. A fresh 'm' load then yields only the new bytes.
